// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the ctrl_pipe control pipeline: result-source and
// forward-select encodings, register index width, stage record types and
// the forwarding priority helper used by the hazard unit.
package ctrl_pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] regIdx_t;

    // Where the W stage takes its write-back value from; RES_LOAD marks a load.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } resultSrc_e;

    // Operand source selection for the E-stage ALU inputs.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_W       = 2'b01,
        FWD_M       = 2'b10
    } forwardSel_e;

    // Everything the E stage carries for one instruction.
    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic       aluSrc;
        logic [2:0] operation;
        logic       branch;
        logic       jump;
        regIdx_t    rs1;
        regIdx_t    rs2;
        regIdx_t    rd;
    } ctrlE_t;

    // Memory stage keeps only what memory access and write-back still need.
    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        regIdx_t    rd;
    } ctrlM_t;

    // Write-back stage keeps only the register-file write controls.
    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic [1:0] resultSrc;
        regIdx_t    rd;
    } ctrlW_t;

    // An empty E slot: no side effects, no register references, not valid.
    localparam ctrlE_t BUBBLE_E = '0;

    // The younger producer (M) wins over the older one (W); x0 never forwards
    // because it is hard-wired to zero in the register file.
    function automatic forwardSel_e forwardSelect(
        input regIdx_t rsE,
        input logic    regWriteM,
        input logic    validM,
        input regIdx_t rdM,
        input logic    regWriteW,
        input logic    validW,
        input regIdx_t rdW
    );
        forwardSel_e sel;
        sel = FWD_REGFILE;
        if (regWriteM && validM && (rdM != '0) && (rdM == rsE)) begin
            sel = FWD_M;
        end else if (regWriteW && validW && (rdW != '0) && (rdW == rsE)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_detect.sv
// Combinational hazard unit: detects load-use stalls, resolves taken
// branches/jumps in E, and picks operand forwarding for the E stage.
module hazard_detect
    import ctrl_pipe_pkg::*;
(
    input  logic                 i_validE,
    input  logic [1:0]           i_resultSrcE,
    input  logic [REG_IDX_W-1:0] i_rdE,
    input  logic [REG_IDX_W-1:0] i_rs1E,
    input  logic [REG_IDX_W-1:0] i_rs2E,
    input  logic                 i_branchE,
    input  logic                 i_jumpE,
    input  logic                 i_zeroE,
    input  logic [REG_IDX_W-1:0] i_rs1D,
    input  logic [REG_IDX_W-1:0] i_rs2D,
    input  logic                 i_validM,
    input  logic                 i_regWriteM,
    input  logic [REG_IDX_W-1:0] i_rdM,
    input  logic                 i_validW,
    input  logic                 i_regWriteW,
    input  logic [REG_IDX_W-1:0] i_rdW,
    output logic                 o_stallF,
    output logic                 o_stallD,
    output logic                 o_flushD,
    output logic                 o_flushE,
    output logic                 o_pcSrcE,
    output logic [1:0]           o_forwardAE,
    output logic [1:0]           o_forwardBE
);

    logic        w_lwStall;
    logic        w_pcSrc;
    forwardSel_e w_forwardA;
    forwardSel_e w_forwardB;

    // A load in E whose destination is read by the D instruction must hold D
    // for a cycle; a taken branch or jump in E redirects the PC.
    always_comb begin
        w_lwStall = i_validE && (i_resultSrcE == RES_LOAD) && (i_rdE != '0) &&
                    ((i_rdE == i_rs1D) || (i_rdE == i_rs2D));
        w_pcSrc   = i_validE && ((i_branchE && i_zeroE) || i_jumpE);
    end

    // A redirect squashes the younger instructions anyway, so it overrides the
    // stall instead of holding a wrong-path instruction in D.
    always_comb begin
        o_pcSrcE = w_pcSrc;
        o_stallF = w_lwStall && !w_pcSrc;
        o_stallD = w_lwStall && !w_pcSrc;
        o_flushD = w_pcSrc;
        o_flushE = w_lwStall || w_pcSrc;
    end

    // Choose the freshest in-flight value for each E-stage source operand.
    always_comb begin
        w_forwardA  = forwardSelect(i_rs1E, i_regWriteM, i_validM, i_rdM,
                                    i_regWriteW, i_validW, i_rdW);
        w_forwardB  = forwardSelect(i_rs2E, i_regWriteM, i_validM, i_rdM,
                                    i_regWriteW, i_validW, i_rdW);
        o_forwardAE = w_forwardA;
        o_forwardBE = w_forwardB;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control path of a 5-stage in-order pipeline: carries decoded control
// fields from D through E, M and W, inserts bubbles on flush, hosts the
// hazard unit and counts retired instructions.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegWrite_D,
    input  logic [1:0]           ResultSrc_D,
    input  logic                 MemWrite_D,
    input  logic                 ALUSrc_D,
    input  logic [2:0]           Operation_D,
    input  logic                 Branch_D,
    input  logic                 Jump_D,
    input  logic                 Valid_D,
    input  logic [REG_IDX_W-1:0] Rs1_D,
    input  logic [REG_IDX_W-1:0] Rs2_D,
    input  logic [REG_IDX_W-1:0] Rd_D,
    input  logic                 Zero_E,
    output logic                 RegWrite_E,
    output logic [1:0]           ResultSrc_E,
    output logic                 MemWrite_E,
    output logic                 ALUSrc_E,
    output logic [2:0]           Operation_E,
    output logic                 Branch_E,
    output logic                 Jump_E,
    output logic [REG_IDX_W-1:0] Rs1_E,
    output logic [REG_IDX_W-1:0] Rs2_E,
    output logic [REG_IDX_W-1:0] Rd_E,
    output logic                 RegWrite_M,
    output logic [1:0]           ResultSrc_M,
    output logic                 MemWrite_M,
    output logic [REG_IDX_W-1:0] Rd_M,
    output logic                 RegWrite_W,
    output logic [1:0]           ResultSrc_W,
    output logic [REG_IDX_W-1:0] Rd_W,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 PCSrc_E,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [31:0]          Retired
);

    ctrlE_t      r_stageE;
    ctrlM_t      r_stageM;
    ctrlW_t      r_stageW;
    logic [31:0] r_retired;

    ctrlE_t      w_nextE;
    logic        w_flushE;

    hazard_detect u_hazard (
        .i_validE     (r_stageE.valid),
        .i_resultSrcE (r_stageE.resultSrc),
        .i_rdE        (r_stageE.rd),
        .i_rs1E       (r_stageE.rs1),
        .i_rs2E       (r_stageE.rs2),
        .i_branchE    (r_stageE.branch),
        .i_jumpE      (r_stageE.jump),
        .i_zeroE      (Zero_E),
        .i_rs1D       (Rs1_D),
        .i_rs2D       (Rs2_D),
        .i_validM     (r_stageM.valid),
        .i_regWriteM  (r_stageM.regWrite),
        .i_rdM        (r_stageM.rd),
        .i_validW     (r_stageW.valid),
        .i_regWriteW  (r_stageW.regWrite),
        .i_rdW        (r_stageW.rd),
        .o_stallF     (StallF),
        .o_stallD     (StallD),
        .o_flushD     (FlushD),
        .o_flushE     (w_flushE),
        .o_pcSrcE     (PCSrc_E),
        .o_forwardAE  (ForwardAE),
        .o_forwardBE  (ForwardBE)
    );

    assign FlushE = w_flushE;

    // E never holds: a stalled D instruction is simply re-presented by the
    // front end while a bubble takes its place in E.
    always_comb begin
        w_nextE = BUBBLE_E;
        if (!w_flushE) begin
            w_nextE.valid     = Valid_D;
            w_nextE.regWrite  = RegWrite_D;
            w_nextE.resultSrc = ResultSrc_D;
            w_nextE.memWrite  = MemWrite_D;
            w_nextE.aluSrc    = ALUSrc_D;
            w_nextE.operation = Operation_D;
            w_nextE.branch    = Branch_D;
            w_nextE.jump      = Jump_D;
            w_nextE.rs1       = Rs1_D;
            w_nextE.rs2       = Rs2_D;
            w_nextE.rd        = Rd_D;
        end
    end

    // Advance every stage each cycle; reset drops all in-flight instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stageE <= BUBBLE_E;
            r_stageM <= '0;
            r_stageW <= '0;
        end else begin
            r_stageE           <= w_nextE;
            r_stageM.valid     <= r_stageE.valid;
            r_stageM.regWrite  <= r_stageE.regWrite;
            r_stageM.resultSrc <= r_stageE.resultSrc;
            r_stageM.memWrite  <= r_stageE.memWrite;
            r_stageM.rd        <= r_stageE.rd;
            r_stageW.valid     <= r_stageM.valid;
            r_stageW.regWrite  <= r_stageM.regWrite;
            r_stageW.resultSrc <= r_stageM.resultSrc;
            r_stageW.rd        <= r_stageM.rd;
        end
    end

    // Count an instruction as retired when it leaves W; wraps at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (r_stageW.valid) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign RegWrite_E  = r_stageE.regWrite;
    assign ResultSrc_E = r_stageE.resultSrc;
    assign MemWrite_E  = r_stageE.memWrite;
    assign ALUSrc_E    = r_stageE.aluSrc;
    assign Operation_E = r_stageE.operation;
    assign Branch_E    = r_stageE.branch;
    assign Jump_E      = r_stageE.jump;
    assign Rs1_E       = r_stageE.rs1;
    assign Rs2_E       = r_stageE.rs2;
    assign Rd_E        = r_stageE.rd;
    assign RegWrite_M  = r_stageM.regWrite;
    assign ResultSrc_M = r_stageM.resultSrc;
    assign MemWrite_M  = r_stageM.memWrite;
    assign Rd_M        = r_stageM.rd;
    assign RegWrite_W  = r_stageW.regWrite;
    assign ResultSrc_W = r_stageW.resultSrc;
    assign Rd_W        = r_stageW.rd;
    assign Retired     = r_retired;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe: load-use stalls, forwarding priority,
// branch/jump flushes, x0 handling, asynchronous reset and retire counting.
module tb_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic        RegWrite_D;
    logic [1:0]  ResultSrc_D;
    logic        MemWrite_D;
    logic        ALUSrc_D;
    logic [2:0]  Operation_D;
    logic        Branch_D;
    logic        Jump_D;
    logic        Valid_D;
    logic [4:0]  Rs1_D;
    logic [4:0]  Rs2_D;
    logic [4:0]  Rd_D;
    logic        Zero_E;
    logic        RegWrite_E;
    logic [1:0]  ResultSrc_E;
    logic        MemWrite_E;
    logic        ALUSrc_E;
    logic [2:0]  Operation_E;
    logic        Branch_E;
    logic        Jump_E;
    logic [4:0]  Rs1_E;
    logic [4:0]  Rs2_E;
    logic [4:0]  Rd_E;
    logic        RegWrite_M;
    logic [1:0]  ResultSrc_M;
    logic        MemWrite_M;
    logic [4:0]  Rd_M;
    logic        RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [4:0]  Rd_W;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        PCSrc_E;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] Retired;

    int compareCount = 0;
    int failCount    = 0;

    ctrl_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegWrite_D  (RegWrite_D),
        .ResultSrc_D (ResultSrc_D),
        .MemWrite_D  (MemWrite_D),
        .ALUSrc_D    (ALUSrc_D),
        .Operation_D (Operation_D),
        .Branch_D    (Branch_D),
        .Jump_D      (Jump_D),
        .Valid_D     (Valid_D),
        .Rs1_D       (Rs1_D),
        .Rs2_D       (Rs2_D),
        .Rd_D        (Rd_D),
        .Zero_E      (Zero_E),
        .RegWrite_E  (RegWrite_E),
        .ResultSrc_E (ResultSrc_E),
        .MemWrite_E  (MemWrite_E),
        .ALUSrc_E    (ALUSrc_E),
        .Operation_E (Operation_E),
        .Branch_E    (Branch_E),
        .Jump_E      (Jump_E),
        .Rs1_E       (Rs1_E),
        .Rs2_E       (Rs2_E),
        .Rd_E        (Rd_E),
        .RegWrite_M  (RegWrite_M),
        .ResultSrc_M (ResultSrc_M),
        .MemWrite_M  (MemWrite_M),
        .Rd_M        (Rd_M),
        .RegWrite_W  (RegWrite_W),
        .ResultSrc_W (ResultSrc_W),
        .Rd_W        (Rd_W),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .PCSrc_E     (PCSrc_E),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .Retired     (Retired)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence end");
        $fatal(1, "[TB] timeout");
    end

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one decoded instruction to the D-stage inputs; ALUSrc and
    // Operation are derived from the registers so they are distinguishable.
    task automatic applyStimulus(input logic valid, input logic regWrite,
                                 input logic [1:0] resultSrc, input logic memWrite,
                                 input logic branch, input logic jump,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd);
        Valid_D     = valid;
        RegWrite_D  = regWrite;
        ResultSrc_D = resultSrc;
        MemWrite_D  = memWrite;
        Branch_D    = branch;
        Jump_D      = jump;
        Rs1_D       = rs1;
        Rs2_D       = rs2;
        Rd_D        = rd;
        ALUSrc_D    = rs1[0];
        Operation_D = rd[2:0];
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Move to the next falling edge, one rising edge later.
    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyNop();
            nextCycle();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        Zero_E = 1'b0;
        applyNop();

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst RegWrite_E", 32'(RegWrite_E), 32'd0);
        checkOutput("rst Rd_M", 32'(Rd_M), 32'd0);
        checkOutput("rst RegWrite_W", 32'(RegWrite_W), 32'd0);
        checkOutput("rst Retired", Retired, 32'd0);
        checkOutput("rst StallF", 32'(StallF), 32'd0);
        checkOutput("rst FlushE", 32'(FlushE), 32'd0);
        checkOutput("rst ForwardAE", 32'(ForwardAE), 32'd0);
        rst_n = 1'b1;
        nextCycle();
        idle(2);

        // Load x5 then use x5 as Rs1
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5);
        #1;
        checkOutput("lu0 StallF", 32'(StallF), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 5'd6);
        #1;
        checkOutput("lu1 StallF", 32'(StallF), 32'd1);
        checkOutput("lu1 StallD", 32'(StallD), 32'd1);
        checkOutput("lu1 FlushE", 32'(FlushE), 32'd1);
        checkOutput("lu1 FlushD", 32'(FlushD), 32'd0);
        checkOutput("lu1 Rd_E", 32'(Rd_E), 32'd5);
        checkOutput("lu1 ResultSrc_E", 32'(ResultSrc_E), 32'd1);
        checkOutput("lu1 Rs1_E", 32'(Rs1_E), 32'd1);
        checkOutput("lu1 Rs2_E", 32'(Rs2_E), 32'd2);
        checkOutput("lu1 ALUSrc_E", 32'(ALUSrc_E), 32'd1);
        checkOutput("lu1 Operation_E", 32'(Operation_E), 32'd5);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 5'd6);
        #1;
        checkOutput("lu2 StallF", 32'(StallF), 32'd0);
        checkOutput("lu2 FlushE", 32'(FlushE), 32'd0);
        checkOutput("lu2 bubble RegWrite_E", 32'(RegWrite_E), 32'd0);
        checkOutput("lu2 bubble Rd_E", 32'(Rd_E), 32'd0);
        checkOutput("lu2 Rd_M", 32'(Rd_M), 32'd5);
        checkOutput("lu2 ResultSrc_M", 32'(ResultSrc_M), 32'd1);
        nextCycle();
        applyNop();
        #1;
        checkOutput("lu3 Rd_E", 32'(Rd_E), 32'd6);
        checkOutput("lu3 ForwardAE", 32'(ForwardAE), 32'd1);
        checkOutput("lu3 ForwardBE", 32'(ForwardBE), 32'd0);
        checkOutput("lu3 Rd_W", 32'(Rd_W), 32'd5);
        checkOutput("lu3 RegWrite_W", 32'(RegWrite_W), 32'd1);
        checkOutput("lu3 ResultSrc_W", 32'(ResultSrc_W), 32'd1);
        idle(3);

        // Load-use through Rs2
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd1);
        #1;
        checkOutput("lu rs2 StallD", 32'(StallD), 32'd1);
        idle(4);

        // Load to x0 followed by a read of x0
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2);
        #1;
        checkOutput("x0 StallF", 32'(StallF), 32'd0);
        checkOutput("x0 FlushE", 32'(FlushE), 32'd0);
        nextCycle();
        applyNop();
        #1;
        checkOutput("x0 ForwardAE", 32'(ForwardAE), 32'd0);
        idle(3);

        // Back-to-back producer/consumer on x7 via Rs2
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd10);
        nextCycle();
        applyNop();
        #1;
        checkOutput("fwdM ForwardBE", 32'(ForwardBE), 32'd2);
        checkOutput("fwdM ForwardAE", 32'(ForwardAE), 32'd0);
        idle(3);

        // Same dependency with one unrelated instruction in between
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd11);
        nextCycle();
        applyNop();
        #1;
        checkOutput("fwdW ForwardBE", 32'(ForwardBE), 32'd1);
        idle(3);

        // Both M and W write x9; the younger (M) must win
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd13);
        nextCycle();
        applyNop();
        #1;
        checkOutput("prio ForwardAE", 32'(ForwardAE), 32'd2);
        checkOutput("prio ForwardBE", 32'(ForwardBE), 32'd2);
        idle(3);

        // Taken branch
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4);
        Zero_E = 1'b1;
        #1;
        checkOutput("br Branch_E", 32'(Branch_E), 32'd1);
        checkOutput("br PCSrc_E", 32'(PCSrc_E), 32'd1);
        checkOutput("br FlushD", 32'(FlushD), 32'd1);
        checkOutput("br FlushE", 32'(FlushE), 32'd1);
        checkOutput("br StallF", 32'(StallF), 32'd0);
        nextCycle();
        applyNop();
        Zero_E = 1'b0;
        #1;
        checkOutput("br bubble RegWrite_E", 32'(RegWrite_E), 32'd0);
        checkOutput("br bubble MemWrite_E", 32'(MemWrite_E), 32'd0);
        checkOutput("br bubble PCSrc_E", 32'(PCSrc_E), 32'd0);
        idle(3);

        // Not-taken branch
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4);
        Zero_E = 1'b0;
        #1;
        checkOutput("nt PCSrc_E", 32'(PCSrc_E), 32'd0);
        checkOutput("nt FlushD", 32'(FlushD), 32'd0);
        checkOutput("nt FlushE", 32'(FlushE), 32'd0);
        nextCycle();
        applyNop();
        #1;
        checkOutput("nt RegWrite_E", 32'(RegWrite_E), 32'd1);
        checkOutput("nt MemWrite_E", 32'(MemWrite_E), 32'd1);
        checkOutput("nt MemWrite_M", 32'(MemWrite_M), 32'd0);
        idle(3);

        // Load-use stall coinciding with a taken jump in E
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6);
        #1;
        checkOutput("jlu Jump_E", 32'(Jump_E), 32'd1);
        checkOutput("jlu StallF", 32'(StallF), 32'd0);
        checkOutput("jlu StallD", 32'(StallD), 32'd0);
        checkOutput("jlu FlushD", 32'(FlushD), 32'd1);
        checkOutput("jlu FlushE", 32'(FlushE), 32'd1);
        idle(3);

        // Asynchronous reset clears the retire count left by earlier traffic
        applyNop();
        rst_n = 1'b0;
        #1;
        checkOutput("rst2 Retired", Retired, 32'd0);
        rst_n = 1'b1;
        nextCycle();

        // Ten valid instructions, then reset between edges
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'(k));
            nextCycle();
        end
        applyNop();
        #1;
        checkOutput("str Retired", Retired, 32'd7);
        checkOutput("str Rd_E", 32'(Rd_E), 32'd10);
        checkOutput("str Rd_M", 32'(Rd_M), 32'd9);
        checkOutput("str Rd_W", 32'(Rd_W), 32'd8);
        rst_n = 1'b0;
        #1;
        checkOutput("mid Retired", Retired, 32'd0);
        checkOutput("mid RegWrite_E", 32'(RegWrite_E), 32'd0);
        checkOutput("mid Rd_E", 32'(Rd_E), 32'd0);
        checkOutput("mid RegWrite_M", 32'(RegWrite_M), 32'd0);
        checkOutput("mid RegWrite_W", 32'(RegWrite_W), 32'd0);
        checkOutput("mid Rd_W", 32'(Rd_W), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid held Retired", Retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        #1;
        checkOutput("post Retired", Retired, 32'd0);

        // Counter wrap: preload all-ones just before one instruction retires
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3);
        nextCycle();
        applyNop();
        nextCycle();
        nextCycle();
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        #1;
        checkOutput("wrap preload", Retired, 32'hFFFF_FFFF);
        nextCycle();
        #1;
        checkOutput("wrap Retired", Retired, 32'd0);
        nextCycle();
        #1;
        checkOutput("wrap hold", Retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
